// File: rtl/ha_array_pkg.sv
// ha_array_pkg: shared row-group geometry and weighting helper for the HA array reducer
package ha_array_pkg;
  localparam int HA_GROUPS    = 4;
  localparam int HA_B_W       = 7;
  localparam int HA_T_W       = 9;
  localparam int HA_B_OFS     = 2;
  localparam int HA_GRP_SHIFT = 2;
  localparam int HA_ACC_W     = 18;
  function automatic logic [HA_ACC_W-1:0] grp_value(input logic [HA_B_W-1:0] b, input logic [HA_T_W-1:0] t, input int k);
    return (HA_ACC_W'(t) + (HA_ACC_W'(b) << HA_B_OFS)) << (HA_GRP_SHIFT * k);
  endfunction
endpackage

// File: rtl/ha_group_weight.sv
// ha_group_weight: combinational weighted value of one bottom/top row pair
module ha_group_weight
  import ha_array_pkg::*;
#(
  parameter int ACC_W = 18,
  parameter int K     = 0
) (
  input  logic [HA_B_W-1:0] b,
  input  logic [HA_T_W-1:0] t,
  output logic [ACC_W-1:0]  g
);
  assign g = ACC_W'(grp_value(b, t, K));
endmodule

// File: rtl/ha_array_reducer.sv
// ha_array_reducer: 2-stage valid/ready reduction of four HA row groups into the product.
// Define HA_ARRAY_REDUCER_SAT_EN to saturate the product on overflow instead of truncating.
module ha_array_reducer
  import ha_array_pkg::*;
#(
  parameter int OUT_W = 16,
  parameter int ACC_W = 18,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [HA_B_W-1:0] ha_b0,
  input  logic [HA_B_W-1:0] ha_b1,
  input  logic [HA_B_W-1:0] ha_b2,
  input  logic [HA_B_W-1:0] ha_b3,
  input  logic [HA_T_W-1:0] ha_t0,
  input  logic [HA_T_W-1:0] ha_t1,
  input  logic [HA_T_W-1:0] ha_t2,
  input  logic [HA_T_W-1:0] ha_t3,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  product,
  output logic              ovf,
  output logic [CNT_W-1:0]  done_cnt
);
  logic [HA_B_W-1:0] b [HA_GROUPS];
  logic [HA_T_W-1:0] t [HA_GROUPS];
  logic [ACC_W-1:0]  g [HA_GROUPS];
  logic [ACC_W-1:0]  s1_lo, s1_hi, sum;
  logic [OUT_W-1:0]  prod_next;
  logic              s1_v, s2_load, sum_ovf;
  assign b = '{ha_b0, ha_b1, ha_b2, ha_b3};
  assign t = '{ha_t0, ha_t1, ha_t2, ha_t3};
  for (genvar i = 0; i < HA_GROUPS; i++) begin : g_grp
    ha_group_weight #(.ACC_W(ACC_W), .K(i)) u_w (.b(b[i]), .t(t[i]), .g(g[i]));
  end
  assign sum     = s1_lo + s1_hi;
  assign sum_ovf = |sum[ACC_W-1:OUT_W];
`ifdef HA_ARRAY_REDUCER_SAT_EN
  assign prod_next = sum_ovf ? '1 : sum[OUT_W-1:0];
`else
  assign prod_next = sum[OUT_W-1:0];
`endif
  assign s2_load  = s1_v && (!out_valid || out_ready);
  assign in_ready = !s1_v || s2_load;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v      <= 1'b0;
      s1_lo     <= '0;
      s1_hi     <= '0;
      out_valid <= 1'b0;
      product   <= '0;
      ovf       <= 1'b0;
      done_cnt  <= '0;
    end else begin
      if (in_ready) s1_v <= in_valid;
      if (in_valid && in_ready) begin
        s1_lo <= g[0] + g[1];
        s1_hi <= g[2] + g[3];
      end
      if (!out_valid || out_ready) out_valid <= s1_v;
      if (s2_load) begin
        product <= prod_next;
        ovf     <= sum_ovf;
      end
      if (out_valid && out_ready) done_cnt <= done_cnt + CNT_W'(1);
    end
  end
endmodule

// File: doc/ha_array_reducer.md
Name: ha_array_reducer

Overview:
- Consumer for the four half-adder row-pair groups (ha_array_k_b / ha_array_k_t, k=0..3) produced by the unsigned 8x8 approximate-multiplier front end.
- Weights and reduces the rows into the final unsigned product through a 2-stage valid/ready pipeline.
- Also keeps a completed-result counter for error-statistics benches.
- Sits between the partial-product/HA front end and the downstream consumer.

Parameters:
- OUT_W, 16, product output width.
- ACC_W, 18, internal accumulation width. Must be at least 17, because approximate "carry-only" cells can push the sum above 2^16-1.
- CNT_W, 16, width of the completed-result counter.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  row-group bundle valid.
- in_ready  out  1  block can accept the bundle this cycle.
- ha_b0, ha_b1, ha_b2, ha_b3  in  7 each  group k bottom (carry) row.
- ha_t0, ha_t1, ha_t2, ha_t3  in  9 each  group k top (sum) row.
- out_valid  out  1  product valid.
- out_ready  in  1  downstream accepts the product.
- product  out  OUT_W  reduced product.
- ovf  out  1  exact reduced sum exceeded 2^OUT_W-1.
- done_cnt  out  CNT_W  number of products accepted downstream.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Bit weights: group k base shift is 2k.
  - t[i] has weight 2^(2k+i), i=0..8.
  - b[i] has weight 2^(2k+i+2), i=0..6.
- Group value: G_k = (t_k + (b_k<<2)) << 2k. Maximum per group before the shift is 1019.
- Stage 1 (s1) registers:
  - s1_lo = G0+G1
  - s1_hi = G2+G3
  - Both are ACC_W bits, with zero-extension before adding.
- Stage 2 (s2) registers:
  - sum = s1_lo+s1_hi
  - product = sum[OUT_W-1:0] (or the saturated value, see Optional Feature)
  - ovf = |sum[ACC_W-1:OUT_W]
- Handshake:
  - s2_load = s1_v && (!s2_v || out_ready)
  - in_ready = !s1_v || s2_load, combinational from the registered valids and out_ready
  - A transfer occurs when in_valid && in_ready.
  - Bubbles collapse; back-to-back throughput is 1 per cycle.
- Latency: 2 cycles from input transfer to out_valid when there is no backpressure.
- Stall: while out_valid && !out_ready, product, ovf and out_valid hold stable. s1 holds if occupied, and in_ready drops once s1 is full.
- Simultaneous events: with s2 draining and s1 loading in the same cycle, both occur. No data is lost or duplicated.
- done_cnt:
  - Increments on each out_valid && out_ready.
  - Wraps from 2^CNT_W-1 to 0 with no flag.
- Reset values: s1_v=0, s2_v=0, out_valid=0, product=0, ovf=0, done_cnt=0. in_ready therefore reads 1 out of reset.
- Reset mid-operation: in-flight data is discarded with no partial output.
- in_valid must stay asserted until accepted. Data changing while in_valid is high and in_ready is low is a protocol violation; behaviour is undefined but must not lock up.
- Input bits carrying constant 0 from "eliminate" cells need no special handling.

Optional Feature:
- Macro: HA_ARRAY_REDUCER_SAT_EN.
- Defined: when ovf=1, product = 2^OUT_W-1 (saturate).
- Undefined: product = sum modulo 2^OUT_W (truncate).
- ovf behaves identically in both builds.

Decomposition:
- Shared package ha_array_pkg holds:
  - constants HA_GROUPS=4, HA_B_W=7, HA_T_W=9, HA_B_OFS=2, HA_GRP_SHIFT=2
  - function grp_value(b,t,k) returning the ACC_W-bit weighted value
- One sub-module: ha_group_weight, a combinational G_k generator instantiated four times.
- Pipeline, handshake and counter stay in the top.

Test Plan:
1. Reset mid-stream:
   - Drop rst_n with both stages full, release it.
   - Required: out_valid=0, in_ready=1, done_cnt=0, and no stale product appears.
2. Single-bit weights, each sent as a separate transfer with all other bits 0:
   - ha_t0=9'h001 -> product=1.
   - ha_b0[0]=1 -> product=4.
   - ha_t3[8]=1 -> product=16384.
   - ha_b3[6]=1 -> product=16384.
   - All with ovf=0 and latency exactly 2 cycles.
3. All-ones on every row:
   - Sum is 86615, so ovf=1.
   - SAT_EN build: product=65535.
   - Truncating build: product=21079.
4. Throughput and ordering:
   - 10 back-to-back transfers with out_ready=1.
   - Required: 10 consecutive out_valid cycles, results in order, done_cnt=10.
5. Backpressure:
   - Hold out_ready=0 for 5 cycles while feeding 3 bundles.
   - Required: in_ready drops after the 2nd acceptance, and product holds stable.
   - On release, all 3 results emerge in order with no loss.
6. Counter wrap:
   - Preload via CNT_W=4 instance, complete 17 transfers.
   - Required: done_cnt=1.
